// File: rtl/line_fill_buffer_if.sv
// Handshake and data bundle between a line fill buffer, its requester,
// the memory port and the line consumer.
interface line_fill_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  req_ready_o;

    logic                  mem_req_valid_o;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic [3:0]            mem_req_word_o;
    logic                  mem_req_ready_i;
    logic                  mem_rsp_valid_i;
    logic [DATA_WIDTH-1:0] mem_rsp_data_i;

    logic                  crit_valid_o;
    logic [DATA_WIDTH-1:0] crit_data_o;
    logic [15:0]           word_valid_o;
    logic [DATA_WIDTH-1:0] word0_o,  word1_o,  word2_o,  word3_o;
    logic [DATA_WIDTH-1:0] word4_o,  word5_o,  word6_o,  word7_o;
    logic [DATA_WIDTH-1:0] word8_o,  word9_o,  word10_o, word11_o;
    logic [DATA_WIDTH-1:0] word12_o, word13_o, word14_o, word15_o;
    logic                  line_valid_o;
    logic [ADDR_WIDTH-1:0] line_addr_o;
    logic                  line_ack_i;
    logic                  busy_o;

    // The fill buffer itself sits on the slave side.
    modport slave (
        input  req_valid_i, req_addr_i, mem_req_ready_i, mem_rsp_valid_i,
               mem_rsp_data_i, line_ack_i,
        output req_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_word_o,
               crit_valid_o, crit_data_o, word_valid_o,
               word0_o,  word1_o,  word2_o,  word3_o,
               word4_o,  word5_o,  word6_o,  word7_o,
               word8_o,  word9_o,  word10_o, word11_o,
               word12_o, word13_o, word14_o, word15_o,
               line_valid_o, line_addr_o, busy_o
    );

    modport master (
        output req_valid_i, req_addr_i, mem_req_ready_i, mem_rsp_valid_i,
               mem_rsp_data_i, line_ack_i,
        input  req_ready_o, mem_req_valid_o, mem_req_addr_o, mem_req_word_o,
               crit_valid_o, crit_data_o, word_valid_o,
               word0_o,  word1_o,  word2_o,  word3_o,
               word4_o,  word5_o,  word6_o,  word7_o,
               word8_o,  word9_o,  word10_o, word11_o,
               word12_o, word13_o, word14_o, word15_o,
               line_valid_o, line_addr_o, busy_o
    );
endinterface

// File: rtl/line_fill_buffer.sv
// Data cache refill buffer: one line-aligned memory read, 16 beats collected in
// critical-word-first wrap order, critical word forwarded, line held until acked.
module line_fill_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              clk_i,
    input logic              rst_n_i,
    line_fill_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] lineAddr_q;
    logic [3:0]            start_q;
    logic [3:0]            count_q;
    logic [15:0]           wordValid_q;
    logic [DATA_WIDTH-1:0] critData_q;
    logic                  critValid_q;
    logic                  reqReady_q;
    logic                  memReqValid_q;
    logic                  lineValid_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] words_q [16];

    logic [3:0]            wrIdx_d;
    logic                  beatTake_d;
    logic                  unusedAddrBits;

    // Byte offset within a word plays no part in line or word selection.
    assign unusedAddrBits = ^bus.req_addr_i[1:0];

    assign wrIdx_d    = start_q + count_q;
    assign beatTake_d = (state_q == FILL) && bus.mem_rsp_valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            lineAddr_q    <= '0;
            start_q       <= '0;
            count_q       <= '0;
            wordValid_q   <= '0;
            critData_q    <= '0;
            critValid_q   <= 1'b0;
            reqReady_q    <= 1'b1;
            memReqValid_q <= 1'b0;
            lineValid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            critValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        lineAddr_q    <= {bus.req_addr_i[ADDR_WIDTH-1:6], 6'b0};
                        start_q       <= bus.req_addr_i[5:2];
                        count_q       <= 4'd0;
                        wordValid_q   <= '0;
                        state_q       <= REQ;
                        reqReady_q    <= 1'b0;
                        memReqValid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready_i) begin
                        state_q       <= FILL;
                        memReqValid_q <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.mem_rsp_valid_i) begin
                        wordValid_q[wrIdx_d] <= 1'b1;
                        count_q              <= count_q + 4'd1;
                        if (count_q == 4'd0) begin
                            critData_q  <= bus.mem_rsp_data_i;
                            critValid_q <= 1'b1;
                        end
                        if (count_q == 4'd15) begin
                            state_q     <= DONE;
                            lineValid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.line_ack_i) begin
                        state_q     <= IDLE;
                        lineValid_q <= 1'b0;
                        reqReady_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage is only written by accepted beats, so it stays frozen in DONE
    // and keeps the old line visible until the next fill overwrites it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 16; k++) begin
                words_q[k] <= '0;
            end
        end else if (beatTake_d) begin
            words_q[wrIdx_d] <= bus.mem_rsp_data_i;
        end
    end

    assign bus.req_ready_o     = reqReady_q;
    assign bus.mem_req_valid_o = memReqValid_q;
    assign bus.mem_req_addr_o  = lineAddr_q;
    assign bus.mem_req_word_o  = start_q;
    assign bus.crit_valid_o    = critValid_q;
    assign bus.crit_data_o     = critData_q;
    assign bus.word_valid_o    = wordValid_q;
    assign bus.line_valid_o    = lineValid_q;
    assign bus.line_addr_o     = lineAddr_q;
    assign bus.busy_o          = busy_q;

    assign bus.word0_o  = words_q[0];
    assign bus.word1_o  = words_q[1];
    assign bus.word2_o  = words_q[2];
    assign bus.word3_o  = words_q[3];
    assign bus.word4_o  = words_q[4];
    assign bus.word5_o  = words_q[5];
    assign bus.word6_o  = words_q[6];
    assign bus.word7_o  = words_q[7];
    assign bus.word8_o  = words_q[8];
    assign bus.word9_o  = words_q[9];
    assign bus.word10_o = words_q[10];
    assign bus.word11_o = words_q[11];
    assign bus.word12_o = words_q[12];
    assign bus.word13_o = words_q[13];
    assign bus.word14_o = words_q[14];
    assign bus.word15_o = words_q[15];

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: table of fill scenarios plus hand-written
// reset-mid-fill and hold/ack sequences.
module tb_line_fill_buffer;

    logic clk;
    logic rstN;
    int   total;
    int   bad;

    line_fill_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifc ();

    line_fill_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rstN),
        .bus     (ifc.slave)
    );

    logic [31:0] wordsOut [16];
    assign wordsOut[0]  = ifc.word0_o;
    assign wordsOut[1]  = ifc.word1_o;
    assign wordsOut[2]  = ifc.word2_o;
    assign wordsOut[3]  = ifc.word3_o;
    assign wordsOut[4]  = ifc.word4_o;
    assign wordsOut[5]  = ifc.word5_o;
    assign wordsOut[6]  = ifc.word6_o;
    assign wordsOut[7]  = ifc.word7_o;
    assign wordsOut[8]  = ifc.word8_o;
    assign wordsOut[9]  = ifc.word9_o;
    assign wordsOut[10] = ifc.word10_o;
    assign wordsOut[11] = ifc.word11_o;
    assign wordsOut[12] = ifc.word12_o;
    assign wordsOut[13] = ifc.word13_o;
    assign wordsOut[14] = ifc.word14_o;
    assign wordsOut[15] = ifc.word15_o;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          stall;
        int          maxGap;
        logic [31:0] expMemAddr;
        logic [3:0]  expMemWord;
        int          chkIdxA;
        logic [31:0] chkValA;
        int          chkIdxB;
        logic [31:0] chkValB;
        int          expLatency;
    } vec_t;

    vec_t vecs [4];

    // Free-running clock; everything is driven and sampled 1 time unit after the rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Whole-line check against the wrap-around placement of base, base+1, ... from start.
    task automatic checkLine(input string name, input logic [3:0] start, input logic [31:0] base);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] off;
            off = 4'(k) - start;
            checkOutput($sformatf("%s word%0d", name, k), {32'h0, wordsOut[k]}, {32'h0, base + 32'(off)});
        end
    endtask

    task automatic sendBeat(input logic [31:0] data);
        ifc.mem_rsp_valid_i = 1'b1;
        ifc.mem_rsp_data_i  = data;
        tick();
        ifc.mem_rsp_valid_i = 1'b0;
        ifc.mem_rsp_data_i  = '0;
    endtask

    // Runs one full fill described by a table entry, leaving the buffer in DONE.
    task automatic applyStimulus(input int id, input vec_t v);
        int cyc;
        int gap;
        string tag;
        tag = $sformatf("vec%0d", id);
        checkOutput({tag, " req_ready before"}, 64'(ifc.req_ready_o), 64'd1);
        ifc.req_valid_i = 1'b1;
        ifc.req_addr_i  = v.addr;
        tick();
        cyc = 1;
        ifc.req_valid_i = 1'b0;
        checkOutput({tag, " req_ready after accept"}, 64'(ifc.req_ready_o), 64'd0);
        checkOutput({tag, " busy"}, 64'(ifc.busy_o), 64'd1);
        for (int s = 0; s < v.stall; s++) begin
            checkOutput({tag, " stall mem_req_valid"}, 64'(ifc.mem_req_valid_o), 64'd1);
            checkOutput({tag, " stall mem_req_addr"}, 64'(ifc.mem_req_addr_o), 64'(v.expMemAddr));
            checkOutput({tag, " stall mem_req_word"}, 64'(ifc.mem_req_word_o), 64'(v.expMemWord));
            tick();
            cyc++;
        end
        checkOutput({tag, " mem_req_valid"}, 64'(ifc.mem_req_valid_o), 64'd1);
        checkOutput({tag, " mem_req_addr"}, 64'(ifc.mem_req_addr_o), 64'(v.expMemAddr));
        checkOutput({tag, " mem_req_word"}, 64'(ifc.mem_req_word_o), 64'(v.expMemWord));
        ifc.mem_req_ready_i = 1'b1;
        tick();
        cyc++;
        ifc.mem_req_ready_i = 1'b0;
        checkOutput({tag, " mem_req_valid drop"}, 64'(ifc.mem_req_valid_o), 64'd0);
        for (int b = 0; b < 16; b++) begin
            gap = (v.maxGap == 0) ? 0 : (b % (v.maxGap + 1));
            for (int g = 0; g < gap; g++) begin
                tick();
                cyc++;
            end
            sendBeat(v.base + 32'(b));
            cyc++;
            checkOutput($sformatf("%s mask count b%0d", tag, b), 64'($countones(ifc.word_valid_o)), 64'(b + 1));
            checkOutput($sformatf("%s crit_valid b%0d", tag, b), 64'(ifc.crit_valid_o), (b == 0) ? 64'd1 : 64'd0);
            checkOutput($sformatf("%s line_valid b%0d", tag, b), 64'(ifc.line_valid_o), (b == 15) ? 64'd1 : 64'd0);
        end
        checkOutput({tag, " crit_data"}, 64'(ifc.crit_data_o), 64'(v.base));
        checkOutput({tag, " latency"}, 64'(cyc), 64'(v.expLatency));
        checkOutput({tag, " word_valid full"}, 64'(ifc.word_valid_o), 64'hFFFF);
        checkOutput({tag, " line_addr"}, 64'(ifc.line_addr_o), 64'(v.expMemAddr));
        checkOutput({tag, " chk word A"}, 64'(wordsOut[v.chkIdxA]), 64'(v.chkValA));
        checkOutput({tag, " chk word B"}, 64'(wordsOut[v.chkIdxB]), 64'(v.chkValB));
        checkLine(tag, v.expMemWord, v.base);
    endtask

    task automatic ackLine(input string tag);
        ifc.line_ack_i = 1'b1;
        tick();
        ifc.line_ack_i = 1'b0;
        checkOutput({tag, " req_ready after ack"}, 64'(ifc.req_ready_o), 64'd1);
        checkOutput({tag, " line_valid after ack"}, 64'(ifc.line_valid_o), 64'd0);
        checkOutput({tag, " busy after ack"}, 64'(ifc.busy_o), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " req_ready"}, 64'(ifc.req_ready_o), 64'd1);
        checkOutput({tag, " busy"}, 64'(ifc.busy_o), 64'd0);
        checkOutput({tag, " mem_req_valid"}, 64'(ifc.mem_req_valid_o), 64'd0);
        checkOutput({tag, " mem_req_addr"}, 64'(ifc.mem_req_addr_o), 64'd0);
        checkOutput({tag, " mem_req_word"}, 64'(ifc.mem_req_word_o), 64'd0);
        checkOutput({tag, " crit_valid"}, 64'(ifc.crit_valid_o), 64'd0);
        checkOutput({tag, " crit_data"}, 64'(ifc.crit_data_o), 64'd0);
        checkOutput({tag, " word_valid"}, 64'(ifc.word_valid_o), 64'd0);
        checkOutput({tag, " line_valid"}, 64'(ifc.line_valid_o), 64'd0);
        checkOutput({tag, " line_addr"}, 64'(ifc.line_addr_o), 64'd0);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("%s word%0d", tag, k), 64'(wordsOut[k]), 64'd0);
        end
    endtask

    // Main sequence: reset, table fills, hold/ack, then reset in the middle of a fill.
    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b0;
        ifc.req_valid_i     = 1'b0;
        ifc.req_addr_i      = '0;
        ifc.mem_req_ready_i = 1'b0;
        ifc.mem_rsp_valid_i = 1'b0;
        ifc.mem_rsp_data_i  = '0;
        ifc.line_ack_i      = 1'b0;

        vecs[0] = '{32'h0000_1000, 32'hA0,   0, 0, 32'h0000_1000, 4'd0,  15, 32'hAF,   0, 32'hA0,   18};
        vecs[1] = '{32'h0000_2037, 32'hD0,   0, 0, 32'h0000_2000, 4'd13,  0, 32'hD3,  12, 32'hDF,   18};
        vecs[2] = '{32'h1234_5678, 32'h100,  4, 3, 32'h1234_5640, 4'd14, 14, 32'h100, 13, 32'h10F,  46};
        vecs[3] = '{32'hFFFF_FFFC, 32'h7000, 1, 1, 32'hFFFF_FFC0, 4'd15, 15, 32'h7000, 0, 32'h7001, 27};

        repeat (3) tick();
        checkResetState("por");
        rstN = 1'b1;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(i, vecs[i]);
            ackLine($sformatf("vec%0d", i));
            tick();
        end

        // Hold: ack withheld for 10 cycles while stray beats and requests arrive.
        applyStimulus(4, '{32'h0000_3010, 32'h50, 0, 0, 32'h0000_3000, 4'd4, 4, 32'h50, 3, 32'h5F, 18});
        for (int c = 0; c < 10; c++) begin
            ifc.mem_rsp_valid_i = 1'b1;
            ifc.mem_rsp_data_i  = 32'hEE00 + 32'(c);
            ifc.req_valid_i     = 1'b1;
            ifc.req_addr_i      = 32'h0000_4000;
            tick();
            checkOutput($sformatf("hold req_ready c%0d", c), 64'(ifc.req_ready_o), 64'd0);
            checkOutput($sformatf("hold line_valid c%0d", c), 64'(ifc.line_valid_o), 64'd1);
            checkOutput($sformatf("hold mask c%0d", c), 64'(ifc.word_valid_o), 64'hFFFF);
        end
        ifc.mem_rsp_valid_i = 1'b0;
        ifc.req_valid_i     = 1'b0;
        checkOutput("hold crit_valid", 64'(ifc.crit_valid_o), 64'd0);
        checkOutput("hold line_addr", 64'(ifc.line_addr_o), 64'h3000);
        checkLine("hold", 4'd4, 32'h50);
        ackLine("hold");
        checkOutput("post-ack mask", 64'(ifc.word_valid_o), 64'hFFFF);
        checkLine("post-ack", 4'd4, 32'h50);

        // New request clears the mask, then a reset lands after 5 beats.
        ifc.req_valid_i = 1'b1;
        ifc.req_addr_i  = 32'h0000_5008;
        tick();
        ifc.req_valid_i = 1'b0;
        checkOutput("newreq mask cleared", 64'(ifc.word_valid_o), 64'd0);
        checkOutput("newreq mem_req_addr", 64'(ifc.mem_req_addr_o), 64'h5000);
        checkOutput("newreq mem_req_word", 64'(ifc.mem_req_word_o), 64'd2);
        ifc.mem_req_ready_i = 1'b1;
        tick();
        ifc.mem_req_ready_i = 1'b0;
        for (int b = 0; b < 5; b++) begin
            sendBeat(32'hC0 + 32'(b));
        end
        checkOutput("midfill mask", 64'(ifc.word_valid_o), 64'h007C);
        checkOutput("midfill word2", 64'(wordsOut[2]), 64'hC0);
        checkOutput("midfill word6", 64'(wordsOut[6]), 64'hC4);
        rstN = 1'b0;
        #1;
        checkResetState("midfill reset");
        tick();
        rstN = 1'b1;
        tick();
        for (int b = 0; b < 3; b++) begin
            sendBeat(32'hBB00 + 32'(b));
        end
        checkResetState("after stray beats");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
